// File: rtl/barret_3557_arbiter.sv
// Round-robin arbiter sharing one combinational mod-3557 Barrett reducer among NUM_REQ requesters.
// Define BARRET_RANGE_CHECK_EN to add a sticky range_err flag on out-of-range reducer results.

module barret_for_3557 (
  input  logic [22:0] din_a,
  output logic [11:0] dout_r
);
  localparam logic [13:0] Q = 14'd3557;
  // m = floor(2^24 / 3557); for 23-bit inputs the quotient estimate is low by at most 2
  localparam logic [35:0] M = 36'd4716;

  logic [11:0] qhat;
  logic [13:0] r0;
  logic [13:0] r1;

  always_comb begin
    qhat   = 12'((36'(din_a) * M) >> 24);
    r0     = 14'({1'b0, din_a} - 24'(qhat) * 24'd3557);
    r1     = (r0 >= Q) ? r0 - Q : r0;
    dout_r = 12'((r1 >= Q) ? r1 - Q : r1);
  end
endmodule

module barret_3557_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DIN_W   = 23,
  parameter int DOUT_W  = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DIN_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]          rsp_valid,
  input  logic [NUM_REQ-1:0]          rsp_ready,
  output logic [NUM_REQ*DOUT_W-1:0]   rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        range_err
);
  localparam int TAG_W = $clog2(NUM_REQ);
  typedef logic [TAG_W-1:0] tag_t;

  logic                      s1_valid_q, s1_valid_d;
  tag_t                      s1_tag_q, s1_tag_d;
  logic [DIN_W-1:0]          s1_data_q, s1_data_d;
  tag_t                      rr_ptr_q, rr_ptr_d;
  tag_t                      grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ*DOUT_W-1:0] rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0] elig;
  logic               gnt_found;
  tag_t               gnt_idx;
  logic [DOUT_W-1:0]  dout_r;

  // A requester with an op in stage 1 or an unconsumed result may not issue again
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid[i] & ~rsp_valid_q[i] & ~(s1_valid_q && (s1_tag_q == tag_t'(i)));
    end
  end

  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_found && elig[tag_t'(idx)]) begin
        gnt_found = 1'b1;
        gnt_idx   = tag_t'(idx);
      end
    end
    req_ready = '0;
    if (gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  // Stage 0 -> 1: capture the granted operand
  always_comb begin
    s1_valid_d = gnt_found;
    s1_tag_d   = s1_tag_q;
    s1_data_d  = s1_data_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    if (gnt_found) begin
      s1_tag_d   = gnt_idx;
      s1_data_d  = req_data[gnt_idx*DIN_W +: DIN_W];
      grant_id_d = gnt_idx;
      rr_ptr_d   = (gnt_idx == tag_t'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  barret_for_3557 u_reducer (
    .din_a  (s1_data_q),
    .dout_r (dout_r)
  );

  // Stage 1 -> response slots: writeback and consumer pop
  always_comb begin
    rsp_valid_d = rsp_valid_q & ~rsp_ready;
    rsp_data_d  = rsp_data_q;
    if (s1_valid_q) begin
      rsp_valid_d[s1_tag_q]                  = 1'b1;
      rsp_data_d[s1_tag_q*DOUT_W +: DOUT_W]  = dout_r;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_tag_q    <= '0;
      s1_data_q   <= '0;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_tag_q    <= s1_tag_d;
      s1_data_q   <= s1_data_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

`ifdef BARRET_RANGE_CHECK_EN
  logic range_err_q, range_err_d;

  always_comb begin
    range_err_d = range_err_q | (s1_valid_q && (dout_r >= DOUT_W'(3557)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) range_err_q <= 1'b0;
    else     range_err_q <= range_err_d;
  end

  assign range_err = range_err_q;
`else
  assign range_err = 1'b0;
`endif

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign grant_id  = grant_id_q;
  assign busy      = s1_valid_q | (|rsp_valid_q);
endmodule

// File: doc/barret_3557_arbiter.md
Name: barret_3557_arbiter

Overview:
- Shares one combinational barret_for_3557 reducer among NUM_REQ requesters.
- Round-robin arbitration and a one-stage operand pipeline feed the reducer.
- A one-entry response slot per requester holds each result.
- Sits between the modular-arithmetic clients (NTT/multiplier lanes) and the single reduction resource, so the reducer is instantiated once rather than per lane.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DIN_W, 23, operand width; must match barret_for_3557 din_a.
- DOUT_W, 12, result width; must match barret_for_3557 dout_r.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_data  input  NUM_REQ*DIN_W  operands; requester i occupies bits [i*DIN_W +: DIN_W].
- rsp_valid  output  NUM_REQ  per-requester result valid.
- rsp_ready  input  NUM_REQ  per-requester result consume.
- rsp_data  output  NUM_REQ*DOUT_W  results; requester i occupies bits [i*DOUT_W +: DOUT_W].
- grant_id  output  clog2(NUM_REQ)  index of the last accepted requester.
- busy  output  1  operation in flight or any result pending.
- range_err  output  1  sticky reducer range fault (see Optional Feature).

Behaviour:
- Reset (asynchronous, rst=1), all values 0:
  - state: s1_valid, s1_tag, s1_data, rr_ptr.
  - outputs: rsp_valid, rsp_data, grant_id, busy, range_err.
  - req_ready is combinational and therefore 0 while no requester is eligible.
- Eligibility:
  - elig[i] = req_valid[i] & ~rsp_valid[i] & ~(s1_valid & s1_tag==i).
  - At most one outstanding operation per requester.
- Arbitration (combinational):
  - Search from rr_ptr cyclically upward; the first eligible index g is granted, and req_ready[g]=1.
  - No eligible index: req_ready all 0.
- Accept = req_valid[g] & req_ready[g], on a rising edge:
  - s1_valid<=1, s1_data<=req_data[g], s1_tag<=g, grant_id<=g.
  - rr_ptr<=(g+1) mod NUM_REQ.
  - No accept: s1_valid<=0, rr_ptr and grant_id hold.
- Reducer: barret_for_3557 din_a is driven by s1_data; dout_r is the combinational result.
- Writeback: when s1_valid, on the edge rsp_data[s1_tag]<=dout_r and rsp_valid[s1_tag]<=1.
- Pipeline timing:
  - Accept at edge N; rsp_valid high after edge N+1, i.e. 2-cycle latency.
  - Aggregate throughput is 1 op/cycle.
  - Stage 1 never stalls; eligibility guarantees a free slot.
- Response handshake:
  - rsp_valid[i] and rsp_data[i] stay stable until rsp_valid[i]&rsp_ready[i].
  - rsp_valid[i] clears on that edge; rsp_data[i] retains its value.
  - rsp_ready while rsp_valid=0 is ignored.
- Same-cycle events:
  - A pop of slot i and a writeback to slot i cannot coincide, by construction.
  - After a pop, requester i becomes eligible the following cycle.
  - Per-requester peak rate is 1 op / 3 cycles when rsp_ready is held high.
- req_ready may depend on req_valid.
  - Requesters hold req_valid and req_data stable until accepted.
  - Requesters must not depend on req_ready to assert valid.
- busy = s1_valid | (|rsp_valid).
- Operands:
  - Any 23-bit value (0..8388607) is legal.
  - Results equal operand mod 3557, in 0..3556.
- Reset mid-operation: the in-flight op and pending results are discarded, with no response; rr_ptr returns to 0.

Optional Feature:
- Macro: BARRET_RANGE_CHECK_EN.
- Defined:
  - When s1_valid and dout_r >= 3557, range_err<=1 on the edge.
  - range_err is sticky until rst.
  - The result is still written back unchanged.
- Undefined: range_err is tied to 0 and the compare logic is absent; port list is unchanged.

Test Plan:
- Single op: req_valid[0]=1, data 7115 -> req_ready[0]=1 same cycle; rsp_valid[0]=1 two edges later, rsp_data[0]=1; busy high throughout.
- Full contention: all four valid from reset, rsp_ready=all 1 -> grants 0,1,2,3 on consecutive edges; each result 2 cycles after its grant.
- Backpressure: rsp_ready[0]=0, requester 0 continuously valid, 1 and 2 valid -> requester 0 not regranted; 1 and 2 served.
  - Then raise rsp_ready[0] -> slot 0 clears, requester 0 granted the next cycle.
- Round robin: after a grant to 2 (rr_ptr=3), requests 1 and 3 -> 3 granted first, then 1.
- Boundary values:
  - 8388607 -> 1201.
  - 3556 -> 3556.
  - 3557 -> 0.
  - 0 -> 0.
  - Sweep 0..3556 on one requester checks identity; range_err stays 0 with BARRET_RANGE_CHECK_EN.
- Mid-op reset: accept on requester 1, assert rst 1 cycle later -> rsp_valid all 0, busy=0, no response afterwards; next grant starts search from index 0.
